bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised BCD countdown timer for the microwave controller: keypad digit entry, start/pause/resume/cancel, and a one-cycle done pulse. Generalises the fixed three-digit minutes/tens/units timer to MIN_DIGITS minute digits and adds a run/pause state machine, seconds normalisation and saturation. Counts down on an external 1 Hz enable pulse; display and cooking-control logic consume its outputs.

## Interface
- MIN_DIGITS, 2, number of BCD minute digits (1..4); maximum time = all minute digits 9, 59 s
- clk  in  1  system clock, all logic on rising edge
- clear  in  1  reset: synchronous and active-low
- tick  in  1  one-clk-wide 1 Hz enable pulse
- digit_valid  in  1  keypad digit strobe, one cycle
- digit  in  4  keypad BCD value; values >9 ignored
- start  in  1  start/resume strobe
- pause  in  1  pause strobe
- cancel  in  1  cancel strobe, clears time
- add30  in  1  "+30 s" strobe (only with TIMER_ADD30_EN)
- minutes  out  4*MIN_DIGITS  BCD minutes, LSD in [3:0]
- tens_sec  out  4  BCD tens of seconds
- units_sec  out  4  BCD units of seconds
- running  out  1  state == RUN
- paused  out  1  state == PAUSE
- zero  out  1  all digits zero (combinational from digit registers)
- done  out  1  one-cycle pulse when countdown reaches zero

## Operation
- States: IDLE, RUN, PAUSE. Reset state IDLE.
- Strobe priority within a cycle: cancel > pause > start > add30 > digit_valid > tick.
- IDLE:
  - digit_valid with digit ≤9: shift left; units←digit, tens←old units, minutes LSD←old tens, each minute digit moves up one place, MSD discarded.
  - start with value nonzero: normalise, then RUN. Start with value zero: ignored.
  - cancel: all digits ←0.
  - tick, pause: ignored.
- Normalisation (on leaving IDLE): if tens_sec >5, tens_sec←tens_sec−6, minutes←minutes+1 (BCD, saturating to maximum time).
- RUN:
  - tick: BCD decrement with borrow. units 0→9 borrows from tens; tens 0→5 borrows from minutes; minute digits 0→9 borrow upward.
  - The tick that takes 0:01 to 0:00 also asserts done and returns to IDLE.
  - pause → PAUSE. cancel → IDLE with digits ←0, no done.
  - start, digit_valid: ignored.
- PAUSE:
  - start → RUN; digits unchanged.
  - cancel → IDLE with digits ←0.
  - tick, digit_valid, pause: ignored.
- Simultaneous events:
  - tick in the same cycle as a higher-priority strobe is dropped; the time is not decremented.
  - clear low overrides everything.

## Timing
- All outputs registered except zero. Each strobe sampled on edge N; its effect is visible after edge N.
- done is high exactly one cycle: the cycle in which the digits first read 0:00, coincident with running falling.
- Reset values (cycle after clk edge with clear=0): all digits 0, state IDLE, running=0, paused=0, done=0, zero=1.
- Countdown latency from start to done is exactly T ticks, where T is the normalised time in seconds.
- Clear asserted mid-RUN: IDLE and zero digits next cycle, no done pulse.

## Configuration
- TIMER_ADD30_EN defined: add30 port present.
  - In RUN or PAUSE: adds 30 s (tens+3; if ≥6, subtract 6 and carry into minutes), saturating at maximum time; state unchanged.
  - In IDLE: normalise, add 30 s, enter RUN. With zero value this gives 0:30 quick-start.
  - add30 and tick in the same cycle: add applied, tick dropped.
- Undefined: add30 port absent, no adder logic, behaviour otherwise identical.

## Test plan
- Reset: clear=0 for 1 cycle from arbitrary state -> digits 00:00, zero=1, running=0, paused=0, done=0.
- Enter 1,3,0, then start, then 90 ticks -> 01:30 displayed before start; running=1; done high exactly once, coincident with 00:00 after the 90th tick; running=0.
- Enter 9,9, then start -> 01:39 one cycle after start; 99 ticks to done.
- Run from 01:05, pause at 01:00, 5 ticks, then start, then 1 tick -> holds 01:00 with paused=1; resumes; 00:59.
- MIN_DIGITS=2: enter 1,2,3,4,5 -> 23:45. Start with zero -> stays IDLE. Pause and tick in the same cycle at 00:10 -> 00:10 held.
- TIMER_ADD30_EN: add30 at 99:45 -> 99:59. add30 in IDLE at 00:00 -> 00:30 and running=1. Cancel plus tick at 00:01 -> 00:00, IDLE, no done.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: keypad entry, run/pause FSM, seconds normalisation and saturation.
// Optional "+30 s" strobe and adder enabled by defining TIMER_ADD30_EN.
module bcd_countdown_timer #(
   parameter int MIN_DIGITS = 2
) (
   input  logic                    i_clk,
   input  logic                    i_clear,
   input  logic                    i_tick,
   input  logic                    i_digit_valid,
   input  logic [3:0]              i_digit,
   input  logic                    i_start,
   input  logic                    i_pause,
   input  logic                    i_cancel,
`ifdef TIMER_ADD30_EN
   input  logic                    i_add30,
`endif
   output logic [4*MIN_DIGITS-1:0] o_minutes,
   output logic [3:0]              o_tens_sec,
   output logic [3:0]              o_units_sec,
   output logic                    o_running,
   output logic                    o_paused,
   output logic                    o_zero,
   output logic                    o_done
);

   // Time is held as one packed word {minutes, tens, units}.
   localparam int TW = 4*MIN_DIGITS + 8;
   localparam logic [TW-1:0] MAX_TIME = {{MIN_DIGITS{4'd9}}, 4'd5, 4'd9};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   state_t          r_state;
   logic [TW-1:0]   r_time;
   logic            r_done;

   logic [TW-1:0]   w_dec;
   logic [TW-1:0]   w_norm;
   logic [TW-1:0]   w_shift;
   logic            w_zero;

   // Replace tens with t_new and carry one into the minutes; saturate if minutes are full.
   function automatic logic [TW-1:0] f_carry(input logic [TW-1:0] v, input logic [3:0] t_new);
      logic c;
      logic sat;
      f_carry = {v[TW-1:8], t_new, v[3:0]};
      c   = 1'b1;
      sat = 1'b1;
      for (int k = 0; k < MIN_DIGITS; k++) begin
         if (v[8+4*k +: 4] != 4'd9) sat = 1'b0;
         if (c) begin
            if (v[8+4*k +: 4] == 4'd9) begin
               f_carry[8+4*k +: 4] = 4'd0;
            end else begin
               f_carry[8+4*k +: 4] = v[8+4*k +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      if (sat) f_carry = MAX_TIME;
   endfunction

   function automatic logic [TW-1:0] f_norm(input logic [TW-1:0] v);
      f_norm = (v[7:4] > 4'd5) ? f_carry(v, v[7:4] - 4'd6) : v;
   endfunction

   function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] v);
      logic b;
      f_dec = v;
      b = 1'b1;
      if (v[3:0] == 4'd0) begin
         f_dec[3:0] = 4'd9;
      end else begin
         f_dec[3:0] = v[3:0] - 4'd1;
         b = 1'b0;
      end
      if (b) begin
         if (v[7:4] == 4'd0) begin
            f_dec[7:4] = 4'd5;
         end else begin
            f_dec[7:4] = v[7:4] - 4'd1;
            b = 1'b0;
         end
      end
      for (int k = 0; k < MIN_DIGITS; k++) begin
         if (b) begin
            if (v[8+4*k +: 4] == 4'd0) begin
               f_dec[8+4*k +: 4] = 4'd9;
            end else begin
               f_dec[8+4*k +: 4] = v[8+4*k +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
   endfunction

`ifdef TIMER_ADD30_EN
   // Assumes tens already normalised (<=5), so tens+3 fits in a nibble.
   function automatic logic [TW-1:0] f_add30(input logic [TW-1:0] v);
      logic [3:0] t3;
      t3 = v[7:4] + 4'd3;
      f_add30 = (t3 >= 4'd6) ? f_carry(v, t3 - 4'd6) : {v[TW-1:8], t3, v[3:0]};
   endfunction

   logic [TW-1:0] w_add_idle;
   logic [TW-1:0] w_add_live;
   assign w_add_idle = f_add30(w_norm);
   assign w_add_live = f_add30(r_time);
`endif

   assign w_dec   = f_dec(r_time);
   assign w_norm  = f_norm(r_time);
   assign w_shift = {r_time[TW-5:0], i_digit};
   assign w_zero  = (r_time == '0);

   // Only the highest-priority strobe of a cycle is acted on; lower ones are dropped.
   always_ff @(posedge i_clk) begin
      if (!i_clear) begin
         r_state <= S_IDLE;
         r_time  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_cancel) begin
            r_state <= S_IDLE;
            r_time  <= '0;
         end else if (i_pause) begin
            if (r_state == S_RUN) r_state <= S_PAUSE;
         end else if (i_start) begin
            if (r_state == S_IDLE && !w_zero) begin
               r_time  <= w_norm;
               r_state <= S_RUN;
            end else if (r_state == S_PAUSE) begin
               r_state <= S_RUN;
            end
`ifdef TIMER_ADD30_EN
         end else if (i_add30) begin
            if (r_state == S_IDLE) begin
               r_time  <= w_add_idle;
               r_state <= S_RUN;
            end else begin
               r_time  <= w_add_live;
            end
`endif
         end else if (i_digit_valid) begin
            if (r_state == S_IDLE && i_digit <= 4'd9) r_time <= w_shift;
         end else if (i_tick && r_state == S_RUN) begin
            r_time <= w_dec;
            if (w_dec == '0) begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
         end
      end
   end

   assign o_minutes   = r_time[TW-1:8];
   assign o_tens_sec  = r_time[7:4];
   assign o_units_sec = r_time[3:0];
   assign o_running   = (r_state == S_RUN);
   assign o_paused    = (r_state == S_PAUSE);
   assign o_zero      = w_zero;
   assign o_done      = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (MIN_DIGITS=2); add30 cases run when TIMER_ADD30_EN is defined.
module tb_bcd_countdown_timer;

   localparam logic [5:0] TK  = 6'd1;
   localparam logic [5:0] DV  = 6'd2;
   localparam logic [5:0] ST  = 6'd4;
   localparam logic [5:0] PA  = 6'd8;
   localparam logic [5:0] CA  = 6'd16;
   localparam logic [5:0] A30 = 6'd32;

   logic       clk = 1'b0;
   logic       i_clear = 1'b0;
   logic       i_tick = 1'b0;
   logic       i_digit_valid = 1'b0;
   logic [3:0] i_digit = 4'd0;
   logic       i_start = 1'b0;
   logic       i_pause = 1'b0;
   logic       i_cancel = 1'b0;
   logic       i_add30 = 1'b0;
   logic [7:0] o_minutes;
   logic [3:0] o_tens_sec;
   logic [3:0] o_units_sec;
   logic       o_running;
   logic       o_paused;
   logic       o_zero;
   logic       o_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(.MIN_DIGITS(2)) dut (
      .i_clk         (clk),
      .i_clear       (i_clear),
      .i_tick        (i_tick),
      .i_digit_valid (i_digit_valid),
      .i_digit       (i_digit),
      .i_start       (i_start),
      .i_pause       (i_pause),
      .i_cancel      (i_cancel),
`ifdef TIMER_ADD30_EN
      .i_add30       (i_add30),
`endif
      .o_minutes     (o_minutes),
      .o_tens_sec    (o_tens_sec),
      .o_units_sec   (o_units_sec),
      .o_running     (o_running),
      .o_paused      (o_paused),
      .o_zero        (o_zero),
      .o_done        (o_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   function automatic logic [31:0] disp();
      return {16'd0, o_minutes, o_tens_sec, o_units_sec};
   endfunction

   // Apply a strobe set for exactly one clock; outputs are then sampled 1 ns after the edge.
   task automatic drive(input logic [5:0] s, input logic [3:0] d);
      {i_add30, i_cancel, i_pause, i_start, i_digit_valid, i_tick} = s;
      i_digit = d;
      @(posedge clk);
      #1;
      {i_add30, i_cancel, i_pause, i_start, i_digit_valid, i_tick} = 6'd0;
   endtask

   task automatic key(input logic [3:0] d);
      drive(DV, d);
   endtask

   initial begin
      int n;
      int dones;

      // reset
      drive(6'd0, 4'd0);
      drive(6'd0, 4'd0);
      i_clear = 1'b1;
      check("rst_time", disp(), 32'h0000);
      check("rst_zero", {31'd0, o_zero}, 32'd1);
      check("rst_run", {31'd0, o_running}, 32'd0);
      check("rst_pause", {31'd0, o_paused}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);

      // 1,3,0 -> 01:30, 90 ticks
      key(4'd1); key(4'd3); key(4'd0);
      check("entry_130", disp(), 32'h0130);
      check("entry_zero", {31'd0, o_zero}, 32'd0);
      drive(ST, 4'd0);
      check("start_run", {31'd0, o_running}, 32'd1);
      check("start_130", disp(), 32'h0130);
      drive(TK, 4'd0);
      check("tick1", disp(), 32'h0129);
      dones = 0;
      for (int k = 2; k <= 89; k++) begin
         drive(TK, 4'd0);
         if (o_done) dones++;
         if (k == 31) check("tick31_borrow", disp(), 32'h0059);
      end
      check("no_early_done", dones, 0);
      drive(TK, 4'd0);
      check("tick90_time", disp(), 32'h0000);
      check("tick90_done", {31'd0, o_done}, 32'd1);
      check("tick90_run", {31'd0, o_running}, 32'd0);
      drive(6'd0, 4'd0);
      check("done_1cyc", {31'd0, o_done}, 32'd0);

      // 9,9 -> normalised 01:39, 99 ticks
      key(4'd9); key(4'd9);
      check("entry_99", disp(), 32'h0099);
      drive(ST, 4'd0);
      check("norm_139", disp(), 32'h0139);
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         drive(TK, 4'd0);
         if (o_done) begin
            n = k;
            break;
         end
      end
      check("ticks_99", n, 99);
      check("t99_time", disp(), 32'h0000);

      // pause / resume
      key(4'd1); key(4'd0); key(4'd5);
      drive(ST, 4'd0);
      for (int k = 0; k < 5; k++) drive(TK, 4'd0);
      check("at_100", disp(), 32'h0100);
      drive(PA, 4'd0);
      check("paused", {31'd0, o_paused}, 32'd1);
      check("paused_run", {31'd0, o_running}, 32'd0);
      for (int k = 0; k < 5; k++) drive(TK, 4'd0);
      check("pause_hold", disp(), 32'h0100);
      drive(ST, 4'd0);
      check("resume_run", {31'd0, o_running}, 32'd1);
      drive(TK, 4'd0);
      check("resume_059", disp(), 32'h0059);
      drive(CA, 4'd0);
      check("cancel_time", disp(), 32'h0000);
      check("cancel_run", {31'd0, o_running}, 32'd0);

      // shift, zero start, pause+tick
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
      check("shift_2345", disp(), 32'h2345);
      drive(CA, 4'd0);
      drive(ST, 4'd0);
      check("zero_start", {31'd0, o_running}, 32'd0);
      key(4'd1); key(4'd0);
      drive(ST, 4'd0);
      drive(PA | TK, 4'd0);
      check("pause_tick_hold", disp(), 32'h0010);
      check("pause_tick_st", {31'd0, o_paused}, 32'd1);
      drive(CA, 4'd0);

      // saturating normalisation and invalid digit
      key(4'd9); key(4'd9); key(4'd9); key(4'd9);
      drive(ST, 4'd0);
      check("norm_sat", disp(), 32'h9959);
      drive(CA, 4'd0);
      key(4'd1); key(4'd12);
      check("bad_digit", disp(), 32'h0001);

      // cancel + tick at 00:01
      drive(ST, 4'd0);
      drive(CA | TK, 4'd0);
      check("cantick_time", disp(), 32'h0000);
      check("cantick_run", {31'd0, o_running}, 32'd0);
      check("cantick_done", {31'd0, o_done}, 32'd0);

      // clear mid-run
      key(4'd5);
      drive(ST, 4'd0);
      drive(TK, 4'd0);
      check("run_004", disp(), 32'h0004);
      i_clear = 1'b0;
      drive(6'd0, 4'd0);
      i_clear = 1'b1;
      check("clr_time", disp(), 32'h0000);
      check("clr_run", {31'd0, o_running}, 32'd0);
      check("clr_done", {31'd0, o_done}, 32'd0);

`ifdef TIMER_ADD30_EN
      key(4'd9); key(4'd9); key(4'd4); key(4'd5);
      drive(ST, 4'd0);
      drive(A30, 4'd0);
      check("add30_sat", disp(), 32'h9959);
      drive(CA, 4'd0);
      drive(A30, 4'd0);
      check("add30_quick", disp(), 32'h0030);
      check("add30_run", {31'd0, o_running}, 32'd1);
      drive(A30 | TK, 4'd0);
      check("add30_tick", disp(), 32'h0100);
      drive(CA, 4'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
